// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: valid/ready request front-end for a 1-cycle-latency storage block.
// Read data is returned in order through a credit-protected response FIFO.
module mem_req_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [DATA_W-1:0] fifo [RSP_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [CW:0]       used;
    logic              inflight, acc, push, pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // An in-flight read already owns a FIFO slot, so it counts against credit.
    assign used      = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign req_ready = !rst && (used < (CW + 1)'(RSP_DEPTH));
    assign acc       = req_valid && req_ready;
    assign mem_we    = acc && req_we;
    assign mem_addr  = req_addr;
    assign mem_wdata = req_wdata;
    assign push      = inflight;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_valid = count != '0;
    assign rsp_rdata = fifo[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            assert (!(push && !pop && count == CW'(RSP_DEPTH)));
            inflight <= acc && !req_we;
            wr_ptr   <= push ? nxt(wr_ptr) : wr_ptr;
            rd_ptr   <= pop ? nxt(rd_ptr) : rd_ptr;
            count    <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst)
            fifo[wr_ptr] <= mem_rdata;
    end
endmodule
